// File: rtl/systolic_array_v2.sv
// Output-stationary ROWS x COLS integer systolic array with internal
// operand skew, valid/ready load and row-by-row result drain.
module systolic_array_v2 #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       start,
    input  logic [15:0]                k_len,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [ROWS*DATA_W-1:0]     data,
    input  logic [COLS*DATA_W-1:0]     weight,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [COLS*ACC_W-1:0]      result,
    output logic [((ROWS > 1) ? $clog2(ROWS) : 1)-1:0] out_row,
    output logic                       busy,
    output logic                       done
);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int FL = ROWS + COLS - 2;

    typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DRAIN} state_t;

    state_t               state_q;
    logic [15:0]          klen_q, kcnt_q, fcnt_q;
    logic                 in_ready_q, out_valid_q, busy_q, done_q;
    logic [RW-1:0]        row_q, sel;
    logic [COLS*ACC_W-1:0] result_q, res_d;
    logic                 clr, step;

    logic signed [DATA_W-1:0] a_in [ROWS][COLS];
    logic signed [DATA_W-1:0] b_in [ROWS][COLS];
    logic signed [DATA_W-1:0] a_q  [ROWS][COLS];
    logic signed [DATA_W-1:0] b_q  [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_q [ROWS][COLS];
    logic signed [ACC_W-1:0]  acc_d [ROWS][COLS];

    assign clr  = (state_q == IDLE) && start;
    assign step = ((state_q == LOAD) && in_valid) || (state_q == FLUSH);

    // Row i operands wait i steps before reaching column 0
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_rs
        logic signed [DATA_W-1:0] din;
        assign din = (state_q == LOAD) ? data[gi*DATA_W +: DATA_W] : '0;
        if (gi == 0) begin : g_nd
            assign a_in[0][0] = din;
        end else begin : g_d
            logic signed [DATA_W-1:0] sr_q [gi];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < gi; d++) sr_q[d] <= '0;
                end else if (clr) begin
                    for (int d = 0; d < gi; d++) sr_q[d] <= '0;
                end else if (step) begin
                    sr_q[0] <= din;
                    for (int d = 1; d < gi; d++) sr_q[d] <= sr_q[d-1];
                end
            end
            assign a_in[gi][0] = sr_q[gi-1];
        end
    end

    for (genvar gj = 0; gj < COLS; gj++) begin : g_cs
        logic signed [DATA_W-1:0] win;
        assign win = (state_q == LOAD) ? weight[gj*DATA_W +: DATA_W] : '0;
        if (gj == 0) begin : g_nd
            assign b_in[0][0] = win;
        end else begin : g_d
            logic signed [DATA_W-1:0] sr_q [gj];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int d = 0; d < gj; d++) sr_q[d] <= '0;
                end else if (clr) begin
                    for (int d = 0; d < gj; d++) sr_q[d] <= '0;
                end else if (step) begin
                    sr_q[0] <= win;
                    for (int d = 1; d < gj; d++) sr_q[d] <= sr_q[d-1];
                end
            end
            assign b_in[0][gj] = sr_q[gj-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_r
        for (genvar j = 0; j < COLS; j++) begin : g_c
            if (j > 0) begin : g_a
                assign a_in[i][j] = a_q[i][j-1];
            end
            if (i > 0) begin : g_b
                assign b_in[i][j] = b_q[i-1][j];
            end
            assign acc_d[i][j] = clr ? '0 :
                step ? acc_q[i][j] + ACC_W'(a_in[i][j]) * ACC_W'(b_in[i][j])
                     : acc_q[i][j];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    acc_q[i][j] <= '0;
                    a_q[i][j]   <= '0;
                    b_q[i][j]   <= '0;
                end else begin
                    acc_q[i][j] <= acc_d[i][j];
                    if (clr) begin
                        a_q[i][j] <= '0;
                        b_q[i][j] <= '0;
                    end else if (step) begin
                        a_q[i][j] <= a_in[i][j];
                        b_q[i][j] <= b_in[i][j];
                    end
                end
            end
        end
    end

    // Result register is loaded from next-state accumulators
    always_comb begin
        sel   = '0;
        res_d = '0;
        if (state_q == DRAIN && ROWS > 1) sel = row_q + 1'b1;
        for (int j = 0; j < COLS; j++) res_d[j*ACC_W +: ACC_W] = acc_d[sel][j];
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            klen_q      <= '0;
            kcnt_q      <= '0;
            fcnt_q      <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            row_q       <= '0;
            result_q    <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: if (start) begin
                    klen_q <= k_len;
                    kcnt_q <= '0;
                    busy_q <= 1'b1;
                    row_q  <= '0;
                    if (k_len != 16'd0) begin
                        state_q    <= LOAD;
                        in_ready_q <= 1'b1;
                    end else begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        result_q    <= res_d;
                    end
                end
                LOAD: if (in_valid) begin
                    kcnt_q <= kcnt_q + 16'd1;
                    if (kcnt_q == klen_q - 16'd1) begin
                        in_ready_q <= 1'b0;
                        fcnt_q     <= '0;
                        if (FL == 0) begin
                            state_q     <= DRAIN;
                            out_valid_q <= 1'b1;
                            result_q    <= res_d;
                        end else begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    fcnt_q <= fcnt_q + 16'd1;
                    if (fcnt_q == 16'(FL - 1)) begin
                        state_q     <= DRAIN;
                        out_valid_q <= 1'b1;
                        result_q    <= res_d;
                    end
                end
                DRAIN: if (out_ready) begin
                    if (row_q == RW'(ROWS - 1)) begin
                        state_q     <= IDLE;
                        out_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        row_q       <= '0;
                    end else begin
                        row_q    <= row_q + 1'b1;
                        result_q <= res_d;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign out_row   = row_q;
    assign result    = result_q;
endmodule

// File: tb/tb_systolic_array_v2.sv
// Bench for systolic_array_v2: table vectors, hand sequences and
// randomized jobs against a matrix-product reference model.
module tb_systolic_array_v2;
    localparam int R  = 4;
    localparam int C  = 4;
    localparam int DW = 8;
    localparam int AW = 32;
    localparam int FL = R + C - 2;
    localparam int KM = 16;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0;
    logic [15:0]       k_len = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [R*DW-1:0]   data = '0;
    logic [C*DW-1:0]   weight = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [C*AW-1:0]   result;
    logic [1:0]        out_row;
    logic              busy, done;

    logic              w_start = 1'b0;
    logic [15:0]       w_klen = '0;
    logic              w_iv = 1'b0;
    logic              w_ir;
    logic [R*DW-1:0]   w_data = '0;
    logic [C*DW-1:0]   w_weight = '0;
    logic              w_ov;
    logic              w_or = 1'b0;
    logic [C*16-1:0]   w_res;
    logic [1:0]        w_row;
    logic              w_busy, w_done;

    systolic_array_v2 #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(AW)) dut (
        .clk(clk), .reset(reset), .start(start), .k_len(k_len),
        .in_valid(in_valid), .in_ready(in_ready), .data(data),
        .weight(weight), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .out_row(out_row), .busy(busy), .done(done)
    );

    systolic_array_v2 #(.ROWS(R), .COLS(C), .DATA_W(DW), .ACC_W(16)) dut16 (
        .clk(clk), .reset(reset), .start(w_start), .k_len(w_klen),
        .in_valid(w_iv), .in_ready(w_ir), .data(w_data),
        .weight(w_weight), .out_valid(w_ov), .out_ready(w_or),
        .result(w_res), .out_row(w_row), .busy(w_busy), .done(w_done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    int A [R][KM];
    int B [KM][C];
    int E [R][C];

    typedef struct {
        int k;
        int d;
        int w;
        int e;
        int mode;
        int bp;
    } vec_t;

    task automatic chk(input string n, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", n, got, exp);
        end
    endtask

    task automatic chkv(input string n, input logic [C*AW-1:0] got,
                        input logic [C*AW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", n, got, exp);
        end
    endtask

    task automatic model(input int k);
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) begin
                E[i][j] = 0;
                for (int s = 0; s < k; s++) E[i][j] += A[i][s] * B[s][j];
            end
    endtask

    function automatic logic [C*AW-1:0] erow(input int r);
        logic [C*AW-1:0] v;
        for (int j = 0; j < C; j++) v[j*AW +: AW] = E[r][j];
        return v;
    endfunction

    task automatic fill_uniform(input int k, input int d, input int w, input int e);
        for (int s = 0; s < KM; s++) begin
            for (int i = 0; i < R; i++) A[i][s] = d;
            for (int j = 0; j < C; j++) B[s][j] = w;
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) E[i][j] = (k == 0) ? 0 : e;
    endtask

    // mode: 0 no stalls, 1 alternate-cycle stalls, 2 random stalls/ready
    task automatic run_job(input int k, input int mode, input int bp_row,
                           input int bp_n, input string tag);
        int t0, beat, stalls, bps, rows, bp_left, now, exp_ov;
        bit seen_ov, got_done, ir_seen, holding, rdy, v;
        logic [C*AW-1:0] held_r;
        logic [1:0] held_row;
        beat = 0; stalls = 0; bps = 0; rows = 0; bp_left = bp_n;
        seen_ov = 0; got_done = 0; ir_seen = 0; holding = 0;
        exp_ov = 0; held_r = '0; held_row = '0;
        @(negedge clk);
        start = 1'b1; k_len = 16'(k); in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        t0 = cyc;
        start = 1'b0;
        for (int g = 0; g < 600 && !got_done; g++) begin
            now = cyc + 1;
            if (done) begin
                got_done = 1;
                chk({tag, " done cycle"}, now - t0, exp_ov - t0 + R + bps);
                chk({tag, " busy at done"}, busy, 0);
                chk({tag, " rows drained"}, rows, R);
                if (k == 0) chk({tag, " in_ready never"}, ir_seen, 0);
                break;
            end
            if (in_ready) begin
                ir_seen = 1;
                v = (mode == 1) ? (now % 2 == 1) :
                    (mode == 2) ? ($urandom_range(0, 2) != 0) : 1'b1;
                if (v && beat < k) begin
                    for (int i = 0; i < R; i++) data[i*DW +: DW] = 8'(A[i][beat]);
                    for (int j = 0; j < C; j++) weight[j*DW +: DW] = 8'(B[beat][j]);
                    in_valid = 1'b1;
                    beat++;
                end else begin
                    in_valid = 1'b0;
                    data = R*DW'($urandom);
                    stalls++;
                end
            end else begin
                in_valid = 1'($urandom);
                data = R*DW'($urandom);
                weight = C*DW'($urandom);
            end
            if (out_valid) begin
                if (!seen_ov) begin
                    seen_ov = 1;
                    exp_ov = (k == 0) ? t0 + 1 : t0 + k + FL + 1 + stalls;
                    chk({tag, " first out_valid"}, now - t0, exp_ov - t0);
                end
                if (holding) begin
                    chkv({tag, " result hold"}, result, held_r);
                    chk({tag, " out_row hold"}, out_row, held_row);
                end
                if (bp_left > 0 && int'(out_row) == bp_row) begin
                    rdy = 0;
                    bp_left--;
                end else begin
                    rdy = (mode == 2) ? 1'($urandom) : 1'b1;
                end
                out_ready = rdy;
                if (rdy) begin
                    chk({tag, " out_row"}, out_row, rows);
                    chkv({tag, " row"}, result, erow(rows % R));
                    rows++;
                    holding = 0;
                end else begin
                    bps++;
                    holding = 1;
                    held_r = result;
                    held_row = out_row;
                end
            end else begin
                out_ready = 1'($urandom);
            end
            @(negedge clk);
        end
        if (!got_done) chk({tag, " timeout"}, 0, 1);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, " done pulse one cycle"}, done, 0);
    endtask

    vec_t tbl [5];

    initial begin
        tbl[0] = '{k: 4, d: 2,    w: 3,    e: 24,     mode: 0, bp: 0};
        tbl[1] = '{k: 4, d: 2,    w: 3,    e: 24,     mode: 1, bp: 3};
        tbl[2] = '{k: 1, d: -128, w: 127,  e: -16256, mode: 0, bp: 0};
        tbl[3] = '{k: 3, d: -128, w: -128, e: 49152,  mode: 0, bp: 0};
        tbl[4] = '{k: 0, d: 5,    w: 7,    e: 0,      mode: 0, bp: 0};

        #1;
        chk("reset in_ready", in_ready, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset out_row", out_row, 0);
        chkv("reset result", result, '0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        for (int t = 0; t < 5; t++) begin
            fill_uniform(tbl[t].k, tbl[t].d, tbl[t].w, tbl[t].e);
            run_job(tbl[t].k, tbl[t].mode, 1, tbl[t].bp, $sformatf("vec%0d", t));
        end

        for (int s = 0; s < KM; s++) begin
            for (int i = 0; i < R; i++) A[i][s] = (i == s) ? 1 : 0;
            for (int j = 0; j < C; j++) B[s][j] = s + 1 + 4 * j;
        end
        for (int i = 0; i < R; i++)
            for (int j = 0; j < C; j++) E[i][j] = i + 1 + 4 * j;
        run_job(4, 0, 0, 0, "identity");

        @(negedge clk);
        start = 1'b1; k_len = 16'd4;
        @(negedge clk);
        start = 1'b0;
        data = {R{8'sd9}}; weight = {C{8'sd9}}; in_valid = 1'b1;
        repeat (2) @(negedge clk);
        in_valid = 1'b0;
        reset = 1'b0;
        #1;
        chk("abort in_ready", in_ready, 0);
        chk("abort out_valid", out_valid, 0);
        chk("abort busy", busy, 0);
        chk("abort done", done, 0);
        chk("abort out_row", out_row, 0);
        chkv("abort result", result, '0);
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 8; n++) begin
            int k;
            k = (n == 7) ? KM : $urandom_range(1, 12);
            for (int s = 0; s < KM; s++) begin
                for (int i = 0; i < R; i++) A[i][s] = int'($signed(8'($urandom)));
                for (int j = 0; j < C; j++) B[s][j] = int'($signed(8'($urandom)));
            end
            model(k);
            run_job(k, (n == 0) ? 0 : 2, 2, (n == 0) ? 0 : 1,
                    $sformatf("rand%0d", n));
        end

        begin
            int rows;
            bit fin;
            rows = 0; fin = 0;
            @(negedge clk);
            w_start = 1'b1; w_klen = 16'd3; w_or = 1'b1;
            w_data = {R{8'h80}}; w_weight = {C{8'h80}};
            @(negedge clk);
            w_start = 1'b0; w_iv = 1'b1;
            for (int g = 0; g < 100 && !fin; g++) begin
                if (w_done) begin
                    fin = 1;
                end else if (w_ov) begin
                    chk($sformatf("wrap row%0d", rows), longint'(w_res),
                        longint'({C{16'hC000}}));
                    rows++;
                end
                if (!fin) @(negedge clk);
            end
            chk("wrap finished", fin, 1);
            chk("wrap rows", rows, R);
            w_iv = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
